sync_stim_gen: RTL and testbench
================================

Name: sync_stim_gen

Overview:
Stimulus generator in the source (clk) clock domain that produces the data words, strobes and pulses fed into the synchronizer test structures (2FF, pulse and toggle synchronizers). It replaces manual driving of the data bus and strobe/pulse inputs with repeatable, programmable sequences. The sequences are bursts or continuous streams with a programmable inter-word gap. The receiving clock domain sees a known pattern, so corruption or loss across the crossing is detectable.

Parameters:
N, 8, data word width
LFSR_TAPS, 8'hB8, Galois LFSR feedback mask (width N)

Ports:
clk  in  1  source-domain clock
rst_n  in  1  reset, active-low, synchronous
ena  in  1  global enable; low freezes all state, stb_out/pulse_out forced 0
start  in  1  level, sampled in IDLE; begins a sequence
stop  in  1  level; aborts any sequence
mode  in  2  00 INC, 01 LFSR, 10 WALK, 11 CONST
seed  in  N  first word of sequence
gap  in  8  idle cycles between words
burst_len  in  8  words per burst; 0 = continuous
data_out  out  N  current word, stable between strobes
stb_out  out  1  one-cycle strobe, word valid
pulse_out  out  1  one-cycle pulse coincident with stb_out (toggle-sync input)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at burst completion
word_cnt  out  8  words emitted in current sequence

Behaviour:
- Reset: all of the following are 0 on the first clk edge with rst_n=0: data_out, stb_out, pulse_out, busy, done, word_cnt, gap counter. State = IDLE. Reset mid-sequence aborts immediately with no done pulse.
- All outputs are registered.
- FSM states: IDLE, EMIT, GAP, FIN.
- IDLE -> EMIT when start=1 and stop=0 at edge k. At this edge:
  - mode, gap and burst_len are latched;
  - data_out <= seed, except LFSR mode with seed=0, which loads 1;
  - word_cnt <= 0.
- Cycle after edge k: stb_out=pulse_out=1, busy=1.
- EMIT (exactly 1 cycle), on leaving:
  - word_cnt += 1 (wraps 255->0 in continuous mode);
  - if burst_len!=0 and new word_cnt==burst_len -> FIN;
  - else if gap==0 -> EMIT with pattern advanced (strobe every cycle);
  - else -> GAP with counter loaded to gap.
- GAP: counter decrements each cycle. At counter==1, advance the pattern and go to EMIT. Word period = gap+1 cycles.
- FIN: done=1 for one cycle, busy=1; then IDLE. data_out holds the last word.
- Pattern advance, arithmetic mod 2^N:
  - INC: d+1;
  - LFSR: d[0] ? (d>>1)^LFSR_TAPS : d>>1;
  - WALK: rotate left by 1 (seed 0 stays 0);
  - CONST: unchanged.
- stop=1 in any state: next state IDLE, stb/pulse/done 0. data_out and word_cnt hold. stop has priority over start and over burst completion on the same edge.
- start held high: the sequence re-arms on the cycle after FIN. A start while busy is ignored.
- ena=0: state, counters and data_out hold; stb_out, pulse_out and done are 0. On ena return, the pending EMIT/FIN is issued then. No strobe is lost or duplicated.
- Latched config is immune to input changes mid-sequence.

Decomposition:
- Shared package holds:
  - mode encodings MODE_INC/LFSR/WALK/CONST;
  - FSM state encodings;
  - default LFSR_TAPS.
- One natural sub-module: sync_stim_pattern, a combinational next-word function (mode, d) -> d', reused by the receive-side checker.

Test Plan:
1. INC, seed=0x10, gap=0, burst_len=4, start pulse -> stb high 4 consecutive cycles with data 0x10,0x11,0x12,0x13. done 1 cycle after the last strobe, word_cnt=4, busy falls after done.
2. LFSR, seed=0x01, gap=2, burst_len=3 -> strobes every 3 cycles with data 0x01,0xB8,0x5C. done=1 once.
3. WALK, seed=0x80, gap=0, burst_len=0, run 10 cycles then stop -> data 0x80,0x01,0x02,...,0x80 wrap. IDLE the cycle after stop, no done, data_out holds last value.
4. INC, gap=1, burst_len=3, ena low for 5 cycles during GAP -> no strobes while low. Exactly 3 strobes total with correct data. Inter-strobe spacing = 2 + frozen cycles.
5. Continuous INC, rst_n low mid-GAP -> next edge: all outputs 0, state IDLE. start+stop together in IDLE -> stays IDLE, busy=0.
6. LFSR, seed=0x00 -> first word 0x01. CONST, seed=0xA5, burst_len=2 -> two strobes with 0xA5, then done.

Source files
------------

// File: rtl/sync_stim_gen_pkg.sv
// Shared definitions for the synchronizer stimulus generator and its receive-side checker.
// Holds the pattern mode encodings, FSM states and the default LFSR feedback mask.
package sync_stim_gen_pkg;

    localparam logic [1:0] MODE_INC   = 2'b00;
    localparam logic [1:0] MODE_LFSR  = 2'b01;
    localparam logic [1:0] MODE_WALK  = 2'b10;
    localparam logic [1:0] MODE_CONST = 2'b11;

    localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01,
        ST_GAP  = 2'b10,
        ST_FIN  = 2'b11
    } state_t;

endpackage

// File: rtl/sync_stim_gen_pattern.sv
// Combinational next-word function (mode, d) -> d'.
// Kept standalone so the receive-side checker can predict the same sequence.
module sync_stim_pattern
    import sync_stim_gen_pkg::*;
#(
    parameter int             N         = 8,
    parameter logic [N-1:0]   LFSR_TAPS = N'(DEFAULT_LFSR_TAPS)
) (
    input  logic [1:0]   mode,
    input  logic [N-1:0] d,
    output logic [N-1:0] d_next
);

    always_comb begin
        d_next = d;
        case (mode)
            MODE_INC:   d_next = d + N'(1);
            MODE_LFSR:  d_next = d[0] ? ((d >> 1) ^ LFSR_TAPS) : (d >> 1);
            MODE_WALK:  d_next = {d[N-2:0], d[N-1]};
            MODE_CONST: d_next = d;
            default:    d_next = d;
        endcase
    end

endmodule

// File: rtl/sync_stim_gen.sv
// Source-domain stimulus generator: emits programmable word sequences with strobe/pulse
// for the 2FF, pulse and toggle synchronizer test structures.
module sync_stim_gen
    import sync_stim_gen_pkg::*;
#(
    parameter int           N         = 8,
    parameter logic [N-1:0] LFSR_TAPS = N'(DEFAULT_LFSR_TAPS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start,
    input  logic         stop,
    input  logic [1:0]   mode,
    input  logic [N-1:0] seed,
    input  logic [7:0]   gap,
    input  logic [7:0]   burst_len,
    output logic [N-1:0] data_out,
    output logic         stb_out,
    output logic         pulse_out,
    output logic         busy,
    output logic         done,
    output logic [7:0]   word_cnt
);

    state_t       state_q, state_d;
    logic [N-1:0] data_q, data_d;
    logic         stb_q, stb_d;
    logic         pulse_q, pulse_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [7:0]   word_cnt_q, word_cnt_d;
    logic [7:0]   gap_cnt_q, gap_cnt_d;
    logic [1:0]   mode_q, mode_d;
    logic [7:0]   gap_q, gap_d;
    logic [7:0]   burst_q, burst_d;

    logic [N-1:0] data_next;
    logic [7:0]   word_cnt_inc;

    sync_stim_pattern #(
        .N         (N),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_pattern (
        .mode   (mode_q),
        .d      (data_q),
        .d_next (data_next)
    );

    assign word_cnt_inc = word_cnt_q + 8'd1;

    // Strobe/pulse/done default low; ena=0 freezes everything else, then stop beats start and completion.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        stb_d      = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        mode_d     = mode_q;
        gap_d      = gap_q;
        burst_d    = burst_q;

        if (!ena) begin
            stb_d = 1'b0;
        end else if (stop) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            gap_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d     = mode;
                        gap_d      = gap;
                        burst_d    = burst_len;
                        data_d     = (mode == MODE_LFSR && seed == '0) ? N'(1) : seed;
                        word_cnt_d = 8'd0;
                        gap_cnt_d  = 8'd0;
                        state_d    = ST_EMIT;
                        stb_d      = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
                ST_EMIT: begin
                    word_cnt_d = word_cnt_inc;
                    if (burst_q != 8'd0 && word_cnt_inc == burst_q) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else if (gap_q == 8'd0) begin
                        data_d = data_next;
                        stb_d  = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 8'd1) begin
                        data_d    = data_next;
                        state_d   = ST_EMIT;
                        stb_d     = 1'b1;
                        gap_cnt_d = 8'd0;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 8'd1;
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end

        pulse_d = stb_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            stb_q      <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= 8'd0;
            gap_cnt_q  <= 8'd0;
            mode_q     <= MODE_INC;
            gap_q      <= 8'd0;
            burst_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            stb_q      <= stb_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            mode_q     <= mode_d;
            gap_q      <= gap_d;
            burst_q    <= burst_d;
        end
    end

    assign data_out  = data_q;
    assign stb_out   = stb_q;
    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_sync_stim_gen.sv
// Directed bench for sync_stim_gen: bursts, continuous streams, freeze, stop and reset,
// each step checked against hand-computed values.
module tb_sync_stim_gen;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] gap;
    logic [7:0] burst_len;
    logic [7:0] data_out;
    logic       stb_out;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [7:0] word_cnt;

    int total = 0;
    int bad   = 0;

    sync_stim_gen #(.N(8), .LFSR_TAPS(8'hB8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .seed      (seed),
        .gap       (gap),
        .burst_len (burst_len),
        .data_out  (data_out),
        .stb_out   (stb_out),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are applied, one rising edge passes, and outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic e, input logic s, input logic p);
        ena   = e;
        start = s;
        stop  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic configure(input logic [1:0] m, input logic [7:0] s, input logic [7:0] g, input logic [7:0] b);
        mode      = m;
        seed      = s;
        gap       = g;
        burst_len = b;
    endtask

    initial begin
        logic [7:0] walk;
        logic [7:0] lfsr_exp [3];
        int         n_stb;
        int         n_done;

        rst_n = 1'b0;
        configure(2'b00, 8'h00, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rst_data", data_out, 8'h00);
        checkOutput("rst_stb", 8'(stb_out), 8'd0);
        checkOutput("rst_pulse", 8'(pulse_out), 8'd0);
        checkOutput("rst_busy", 8'(busy), 8'd0);
        checkOutput("rst_done", 8'(done), 8'd0);
        checkOutput("rst_wcnt", word_cnt, 8'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("idle_busy", 8'(busy), 8'd0);

        $display("[TB] INC burst of 4, gap 0");
        configure(2'b00, 8'h10, 8'd0, 8'd4);
        applyStimulus(1'b1, 1'b1, 1'b0);
        configure(2'b11, 8'hFF, 8'd7, 8'd0);
        checkOutput("inc_stb0", 8'(stb_out), 8'd1);
        checkOutput("inc_pulse0", 8'(pulse_out), 8'd1);
        checkOutput("inc_busy0", 8'(busy), 8'd1);
        checkOutput("inc_data0", data_out, 8'h10);
        checkOutput("inc_wcnt0", word_cnt, 8'd0);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("inc_stb", 8'(stb_out), 8'd1);
            checkOutput("inc_data", data_out, 8'(8'h10 + i));
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("inc_fin_done", 8'(done), 8'd1);
        checkOutput("inc_fin_stb", 8'(stb_out), 8'd0);
        checkOutput("inc_fin_busy", 8'(busy), 8'd1);
        checkOutput("inc_fin_wcnt", word_cnt, 8'd4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("inc_end_done", 8'(done), 8'd0);
        checkOutput("inc_end_busy", 8'(busy), 8'd0);
        checkOutput("inc_end_data", data_out, 8'h13);

        $display("[TB] LFSR burst of 3, gap 2");
        lfsr_exp = '{8'h01, 8'hB8, 8'h5C};
        configure(2'b01, 8'h01, 8'd2, 8'd3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("lfsr_stb0", 8'(stb_out), 8'd1);
        checkOutput("lfsr_data0", data_out, 8'h01);
        n_stb  = 1;
        n_done = 0;
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("lfsr_stb", 8'(stb_out), (c == 3 || c == 6) ? 8'd1 : 8'd0);
            if (stb_out && n_stb < 3) begin
                checkOutput("lfsr_data", data_out, lfsr_exp[n_stb]);
                n_stb++;
            end
            if (done) n_done++;
        end
        checkOutput("lfsr_done_cnt", 8'(n_done), 8'd1);
        checkOutput("lfsr_end_busy", 8'(busy), 8'd0);

        $display("[TB] WALK continuous then stop");
        configure(2'b10, 8'h80, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        walk = 8'h80;
        checkOutput("walk_data0", data_out, walk);
        for (int i = 1; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            walk = {walk[6:0], walk[7]};
            checkOutput("walk_stb", 8'(stb_out), 8'd1);
            checkOutput("walk_data", data_out, walk);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("walk_stop_busy", 8'(busy), 8'd0);
        checkOutput("walk_stop_stb", 8'(stb_out), 8'd0);
        checkOutput("walk_stop_done", 8'(done), 8'd0);
        checkOutput("walk_stop_data", data_out, 8'h01);
        checkOutput("walk_stop_wcnt", word_cnt, 8'd9);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("walk_idle_done", 8'(done), 8'd0);
        checkOutput("walk_idle_stb", 8'(stb_out), 8'd0);

        $display("[TB] INC gap 1 with ena frozen during GAP");
        configure(2'b00, 8'h20, 8'd1, 8'd3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("frz_data0", data_out, 8'h20);
        checkOutput("frz_stb0", 8'(stb_out), 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("frz_gap_stb", 8'(stb_out), 8'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("frz_low_stb", 8'(stb_out), 8'd0);
            checkOutput("frz_low_pulse", 8'(pulse_out), 8'd0);
            checkOutput("frz_low_busy", 8'(busy), 8'd1);
            checkOutput("frz_low_data", data_out, 8'h20);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("frz_stb1", 8'(stb_out), 8'd1);
        checkOutput("frz_data1", data_out, 8'h21);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("frz_gap2_stb", 8'(stb_out), 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("frz_stb2", 8'(stb_out), 8'd1);
        checkOutput("frz_data2", data_out, 8'h22);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("frz_fin_done", 8'(done), 8'd1);
        checkOutput("frz_fin_stb", 8'(stb_out), 8'd0);
        checkOutput("frz_fin_wcnt", word_cnt, 8'd3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("frz_end_busy", 8'(busy), 8'd0);

        $display("[TB] reset mid-GAP, start with stop");
        configure(2'b00, 8'h33, 8'd3, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rstm_data0", data_out, 8'h33);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rstm_gap_wcnt", word_cnt, 8'd1);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rstm_data", data_out, 8'h00);
        checkOutput("rstm_busy", 8'(busy), 8'd0);
        checkOutput("rstm_stb", 8'(stb_out), 8'd0);
        checkOutput("rstm_done", 8'(done), 8'd0);
        checkOutput("rstm_wcnt", word_cnt, 8'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("ss_busy", 8'(busy), 8'd0);
        checkOutput("ss_stb", 8'(stb_out), 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ss_busy2", 8'(busy), 8'd0);

        $display("[TB] LFSR zero seed and CONST burst");
        configure(2'b01, 8'h00, 8'd0, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("lz_stb", 8'(stb_out), 8'd1);
        checkOutput("lz_data", data_out, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lz_done", 8'(done), 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        configure(2'b11, 8'hA5, 8'd0, 8'd2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("const_stb0", 8'(stb_out), 8'd1);
        checkOutput("const_data0", data_out, 8'hA5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("const_stb1", 8'(stb_out), 8'd1);
        checkOutput("const_data1", data_out, 8'hA5);
        checkOutput("const_wcnt1", word_cnt, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("const_done", 8'(done), 8'd1);
        checkOutput("const_stb2", 8'(stb_out), 8'd0);
        checkOutput("const_wcnt2", word_cnt, 8'd2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("const_end_busy", 8'(busy), 8'd0);
        checkOutput("const_end_data", data_out, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
